// File: rtl/drop_if.sv
// Bus between the sensor front end and drop_controller: bag height input,
// operator request, and the actuator/display outputs.
interface drop_if;
  // height_valid is a one-cycle strobe with no back-pressure (no ready):
  // height is meaningful only in a cycle where height_valid is high.
  logic [7:0] height;
  logic       height_valid;
  logic       drop_req;
  logic       drop_active;
  logic [7:0] countdown;
  logic       armed;
  logic       done;
  logic [7:0] h_ref;

  modport master (
    output height, height_valid, drop_req,
    input  drop_active, countdown, armed, done, h_ref
  );

  modport slave (
    input  height, height_valid, drop_req,
    output drop_active, countdown, armed, done, h_ref
  );
endinterface

// File: rtl/drop_controller.sv
// Waits for a stable bag height, then on operator request drives the drop
// actuator for h_ref * TICK_DIV cycles with a live countdown.
module drop_controller #(
  parameter int TICK_DIV     = 4,
  parameter int HOLD_SAMPLES = 3,
  parameter int TOL          = 2
) (
  input  logic       clk,
  input  logic       rst,
  drop_if.slave      bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEASURE = 3'd1,
    S_ARMED   = 3'd2,
    S_DROP    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    HOLD      = 4'(HOLD_SAMPLES);
  localparam logic [8:0]    TOL9      = 9'(TOL);

  state_t        state_q, state_d;
  logic [7:0]    h_ref_q, h_ref_d;
  logic [3:0]    stable_q, stable_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    countdown_q, countdown_d;
  logic          drop_active_q, drop_active_d;
  logic          done_q, done_d;
  logic          armed_q, armed_d;

  logic [8:0]    dev;
  logic          in_tol;
  logic          strobe;
  logic          zero_h;

  // Deviation kept 9 bits wide so the subtraction can never wrap.
  assign dev    = (bus.height >= h_ref_q) ? ({1'b0, bus.height} - {1'b0, h_ref_q})
                                          : ({1'b0, h_ref_q} - {1'b0, bus.height});
  assign in_tol = (dev <= TOL9);
  assign strobe = bus.height_valid;
  assign zero_h = (bus.height == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      h_ref_q       <= 8'd0;
      stable_q      <= 4'd0;
      tick_q        <= '0;
      countdown_q   <= 8'd0;
      drop_active_q <= 1'b0;
      done_q        <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_ref_q       <= h_ref_d;
      stable_q      <= stable_d;
      tick_q        <= tick_d;
      countdown_q   <= countdown_d;
      drop_active_q <= drop_active_d;
      done_q        <= done_d;
      armed_q       <= armed_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    h_ref_d       = h_ref_q;
    stable_d      = stable_q;
    tick_d        = tick_q;
    countdown_d   = countdown_q;
    drop_active_d = drop_active_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (strobe && !zero_h) begin
          h_ref_d  = bus.height;
          stable_d = 4'd1;
          state_d  = (HOLD == 4'd1) ? S_ARMED : S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (strobe) begin
          if (zero_h) begin
            state_d  = S_IDLE;
            h_ref_d  = 8'd0;
            stable_d = 4'd0;
          end else if (in_tol) begin
            stable_d = stable_q + 4'd1;
            if (stable_q + 4'd1 >= HOLD) state_d = S_ARMED;
          end else begin
            h_ref_d  = bus.height;
            stable_d = 4'd1;
            if (HOLD == 4'd1) state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        // A strobe in the same cycle as drop_req is judged first and can cancel it.
        if (strobe && zero_h) begin
          state_d  = S_IDLE;
          h_ref_d  = 8'd0;
          stable_d = 4'd0;
        end else if (strobe && !in_tol) begin
          h_ref_d  = bus.height;
          stable_d = 4'd1;
          state_d  = (HOLD == 4'd1) ? S_ARMED : S_MEASURE;
        end else if (bus.drop_req) begin
          state_d       = S_DROP;
          countdown_d   = h_ref_q;
          tick_d        = '0;
          drop_active_d = 1'b1;
        end
      end
      S_DROP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (countdown_q != 8'd0) countdown_d = countdown_q - 8'd1;
          if (countdown_q <= 8'd1) begin
            state_d       = S_DONE;
            drop_active_d = 1'b0;
            done_d        = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DONE: begin
        if (strobe && zero_h) begin
          state_d  = S_IDLE;
          h_ref_d  = 8'd0;
          stable_d = 4'd0;
        end
      end
      default: begin
        state_d       = S_IDLE;
        h_ref_d       = 8'd0;
        stable_d      = 4'd0;
        countdown_d   = 8'd0;
        drop_active_d = 1'b0;
      end
    endcase
    armed_d = (state_d == S_ARMED);
  end

  always_comb begin
    bus.drop_active = drop_active_q;
    bus.countdown   = countdown_q;
    bus.armed       = armed_q;
    bus.done        = done_q;
    bus.h_ref       = h_ref_q;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_drop_controller.sv
// Directed and randomized checks of drop_controller against a timestamp-based
// behavioural model of the arm/drop rules.
module tb_drop_controller;
  localparam int TD = 4;
  localparam int HS = 3;
  localparam int TL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  drop_if bus();

  drop_controller #(.TICK_DIV(TD), .HOLD_SAMPLES(HS), .TOL(TL)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: a bag is tracked by its reference height and a run of stable samples;
  // a drop is tracked by the number of cycles elapsed since it started.
  int m_href = 0;
  int m_stable = 0;
  int m_elapsed = 0;
  bit m_armed = 0;
  bit m_drop = 0;
  bit m_wait0 = 0;
  bit m_done = 0;

  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int abs_diff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_step(input bit r, input bit hv, input int h, input bit req);
    m_done = 0;
    if (r) begin
      m_href = 0; m_stable = 0; m_elapsed = 0;
      m_armed = 0; m_drop = 0; m_wait0 = 0;
    end else if (m_drop) begin
      m_elapsed++;
      if (m_elapsed == m_href * TD) begin
        m_drop = 0; m_done = 1; m_wait0 = 1;
      end
    end else if (m_wait0) begin
      if (hv && h == 0) begin
        m_wait0 = 0; m_href = 0; m_stable = 0;
      end
    end else if (m_armed) begin
      if (hv && h == 0) begin
        m_armed = 0; m_href = 0; m_stable = 0;
      end else if (hv && abs_diff(h, m_href) > TL) begin
        m_href = h; m_stable = 1; m_armed = (HS == 1);
      end else if (req) begin
        m_armed = 0; m_drop = 1; m_elapsed = 0;
      end
    end else if (m_href != 0) begin
      if (hv) begin
        if (h == 0) begin
          m_href = 0; m_stable = 0;
        end else if (abs_diff(h, m_href) <= TL) begin
          m_stable++;
          if (m_stable >= HS) m_armed = 1;
        end else begin
          m_href = h; m_stable = 1; m_armed = (HS == 1);
        end
      end
    end else if (hv && h != 0) begin
      m_href = h; m_stable = 1; m_armed = (HS == 1);
    end
  endtask

  function automatic int model_state();
    if (m_drop) return 3;
    if (m_wait0) return 4;
    if (m_armed) return 2;
    if (m_href != 0) return 1;
    return 0;
  endfunction

  task automatic check_all();
    chk("drop_active", bus.drop_active, m_drop);
    chk("countdown", bus.countdown, m_drop ? (m_href - m_elapsed / TD) : 0);
    chk("armed", bus.armed, m_armed);
    chk("done", bus.done, m_done);
    chk("h_ref", bus.h_ref, m_href);
    chk("state", dbg_state, model_state());
  endtask

  task automatic step(input bit r, input bit hv, input int h, input bit req);
    rst              = r;
    bus.height_valid = hv;
    bus.height       = 8'(h);
    bus.drop_req     = req;
    @(posedge clk);
    model_step(r, hv, h, req);
    #1;
    check_all();
  endtask

  task automatic strobe(input int h);
    step(0, 1, h, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0);
  endtask

  int active_cnt;
  int done_cnt;
  int base;
  int h;

  initial begin
    rst = 1'b1;
    bus.height = 8'd0;
    bus.height_valid = 1'b0;
    bus.drop_req = 1'b0;

    // 1: reset with random inputs, then zero strobes stay idle
    step(1, 1'($urandom), $urandom_range(0, 255), 1'($urandom));
    step(1, 1'($urandom), $urandom_range(0, 255), 1'($urandom));
    chk("rst_state", dbg_state, 3'd0);
    strobe(0);
    strobe(0);

    // 2: arming around 100
    strobe(100); strobe(101); strobe(99);
    chk("arm_armed", bus.armed, 1'b1);
    chk("arm_href", bus.h_ref, 8'd100);
    strobe(98);
    chk("arm_keep", bus.armed, 1'b1);
    chk("arm_href_keep", bus.h_ref, 8'd100);
    strobe(0);

    // 3: restart on an out-of-tolerance sample
    strobe(100); strobe(110);
    chk("restart_href", bus.h_ref, 8'd110);
    strobe(111);
    chk("restart_not_armed", bus.armed, 1'b0);
    strobe(110);
    chk("restart_armed", bus.armed, 1'b1);
    strobe(0);

    // 4: drop length for height 5, inputs during the drop must be ignored
    strobe(5); strobe(5); strobe(5);
    for (int v = 5; v >= 0; v--) exp_q.push_back(8'(v));
    step(0, 0, 0, 1);
    active_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step(0, 1'($urandom), $urandom_range(1, 255), 1'($urandom));
      if (bus.drop_active === 1'b1) active_cnt++;
      if (bus.done === 1'b1) done_cnt++;
      if (k % TD == 0 && exp_q.size() > 0) chk("cd_seq", bus.countdown, exp_q.pop_front());
      if (k == 20) chk("done_pulse", bus.done, 1'b1);
    end
    chk("active_len", active_cnt, 20);
    chk("done_len", done_cnt, 1);
    strobe(0);
    chk("post_drop_idle", dbg_state, 3'd0);

    // 5: zero strobe beats drop_req; drop_req ignored while measuring
    strobe(40); strobe(40); strobe(40);
    step(0, 1, 0, 1);
    chk("conflict_no_drop", bus.drop_active, 1'b0);
    idle(); idle();
    strobe(60);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("measure_ignore_req", dbg_state, 3'd1);
    strobe(0);

    // 6: reset seven cycles into a drop of height 50
    strobe(50); strobe(50); strobe(50);
    step(0, 0, 0, 1);
    for (int k = 0; k < 6; k++) idle();
    step(1, 0, 0, 0);
    chk("mid_rst_active", bus.drop_active, 1'b0);
    chk("mid_rst_cd", bus.countdown, 8'd0);
    chk("mid_rst_href", bus.h_ref, 8'd0);
    idle();
    chk("mid_rst_no_done", bus.done, 1'b0);

    // Randomized traffic around a slowly moving base height
    base = $urandom_range(1, 255);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 3) base = $urandom_range(1, 255);
      if ($urandom_range(0, 99) < 10) h = 0;
      else begin
        h = base + $urandom_range(0, 6) - 3;
        if (h < 1) h = 1;
        if (h > 255) h = 255;
      end
      step(($urandom_range(0, 499) == 0), 1'($urandom), h, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/drop_controller.md
# drop_controller

Sequential stage directly downstream of `sensors_input`. It consumes the combined 8-bit baggage `height` and decides when a bag is stable. Once the operator requests a drop, it drives the drop actuator for a time proportional to the measured height. Outputs are a drop-enable level, a live countdown and status flags for the display stage.

## Interface
- `TICK_DIV`, 4: clock cycles per countdown unit; must be ≥1.
- `HOLD_SAMPLES`, 3: consecutive in-tolerance samples required to arm; range 1..15.
- `TOL`, 2: maximum absolute height deviation, in height units, still counted as stable.
- `clk`  in  1  single clock, all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `height`  in  8  unsigned bag height from `sensors_input`; 0 means no bag.
- `height_valid`  in  1  one-cycle strobe; `height` is sampled only when it is high.
- `drop_req`  in  1  operator drop request, level-sensitive, sampled every cycle.
- `drop_active`  out  1  actuator enable; high for the whole drop.
- `countdown`  out  8  remaining drop units; 0 when not dropping.
- `armed`  out  1  bag is stable and the block is waiting for `drop_req`.
- `done`  out  1  one-cycle pulse when a drop completes.
- `h_ref`  out  8  latched reference height; 0 in IDLE.

## Operation
- The block has five states: IDLE, MEASURE, ARMED, DROP, DONE.
- All outputs are registered. On `rst` every output clears to 0, the state goes to IDLE, and `stable_cnt` and `tick_cnt` clear to 0. Reset overrides everything, including reset asserted mid-DROP.
- Deviation is `|height − h_ref|`, computed 9 bits wide with no wrap. "In tolerance" means deviation ≤ `TOL`.
- IDLE, on a strobe with `height` ≠ 0: latch `h_ref`=`height`, set `stable_cnt`=1, go to MEASURE. If `HOLD_SAMPLES`=1, go straight to ARMED instead.
- MEASURE, on each strobe:
  - `height`=0: go to IDLE and clear `h_ref`.
  - In tolerance: `stable_cnt`++. On reaching `HOLD_SAMPLES`, go to ARMED. `h_ref` is not updated.
  - Out of tolerance: `h_ref`=`height`, `stable_cnt`=1.
- ARMED (`armed`=1):
  - A strobe with `height`=0 goes to IDLE.
  - An out-of-tolerance strobe re-latches `h_ref` and goes to MEASURE with `stable_cnt`=1.
  - Otherwise, `drop_req`=1 goes to DROP, loads `countdown`=`h_ref`, clears `tick_cnt`, and sets `drop_active`=1.
  - If a strobe and `drop_req` arrive in the same cycle, the strobe is evaluated first: height 0 or out of tolerance wins and cancels the drop.
- DROP:
  - `tick_cnt` increments every cycle. At `TICK_DIV`−1 it wraps to 0 and `countdown` decrements.
  - When `countdown` goes from 1 to 0: go to DONE, `drop_active`=0, `done`=1.
  - `height_valid` and `drop_req` are ignored for the whole drop.
- DONE: `done` is cleared after its single cycle. The block waits for a strobe with `height`=0, then goes to IDLE. `drop_req` is ignored in DONE.
- `drop_req` is ignored in IDLE and MEASURE. `countdown` is never decremented below 0.

## Timing
- A strobe at edge k updates state and outputs visible after edge k; the block has one-cycle registered latency.
- `armed` rises on the edge that samples the `HOLD_SAMPLES`-th stable strobe.
- `drop_active` rises on the edge that samples `drop_req` in ARMED. It stays high for exactly `h_ref`×`TICK_DIV` cycles.
- `countdown` steps down every `TICK_DIV` cycles. Its first decrement comes `TICK_DIV` cycles after `drop_active` rises.
- `done` is high for exactly the one cycle following `drop_active` falling. It is never high while `drop_active`=1.
- `h_ref`=255 gives the longest drop, 255×`TICK_DIV` cycles, with no overflow of the 8-bit counter.

## Test plan
All scenarios use the default parameters (`TICK_DIV`=4, `HOLD_SAMPLES`=3, `TOL`=2).
1. Reset: assert `rst` for 2 cycles with random inputs -> all outputs 0 and state IDLE. Strobes of 0 leave the block in IDLE.
2. Arming: strobes 100, 101, 99 -> `armed`=1 after the third strobe, `h_ref`=100. Then strobe 98 -> `armed` stays 1, `h_ref` stays 100.
3. Restart: strobes 100, 110, 111, 110 -> `h_ref`=110 after the second strobe. `armed`=1 only after the fourth strobe.
4. Drop length: arm with height 5, pulse `drop_req` -> `drop_active` high exactly 20 cycles. `countdown` reads 5, 4, 3, 2, 1, 0 at 4-cycle steps, then `done` is high for 1 cycle. Strobe 0 afterwards -> IDLE.
5. Same-cycle conflict: in ARMED, strobe 0 together with `drop_req` -> IDLE, `drop_active` never asserts. Also `drop_req` in MEASURE -> no effect.
6. Reset mid-drop: assert `rst` 7 cycles into a drop with `h_ref`=50 -> `drop_active`=0, `countdown`=0 and `h_ref`=0 after that edge, with no `done` pulse.
